// File: rtl/bc_preg_arbiter.sv
// ---------------------------------------------------------------------------
// bc_preg_arbiter
//
// Shares the physical-register broadcast bus among N_REQ execution pipes.
// Each pipe hands one result (preg index, areg index, data) into its own
// 1-entry holding slot through a valid/ready handshake. A round-robin
// arbiter moves one slot per cycle onto the registered broadcast bus.
//
// Ports
//   c_clock      : clock, rising edge
//   c_reset      : asynchronous, active-low reset
//   c_pause      : stall -- no grant, no accept, slots and pointer frozen
//   c_flush      : drop all pending results (wins over pause and accept)
//   req_valid    : [N_REQ]   pipe k offers a result
//   req_ready    : [N_REQ]   pipe k result taken at this edge if valid&ready
//   req_i_preg   : packed preg index per pipe, slice k = [k*W +: W]
//   req_i_areg   : packed areg index per pipe
//   req_d_preg   : packed result data per pipe
//   i_preg_rb1   : broadcast preg index, 0 = no broadcast this cycle
//   i_areg_rb1   : broadcast areg index (meaningful only when preg != 0)
//   d_preg_rb1   : broadcast data       (meaningful only when preg != 0)
//   s_busy       : at least one holding slot is occupied
//
// Optional feature (macro BC_PREG_ARB_STAT_EN):
//   s_cnt_bc     : [16] saturating count of edges with a broadcast grant
//   s_cnt_conf   : [16] saturating count of grants made while >=2 slots
//                  were waiting (contention)
//   Both are cleared only by reset, never by flush.
// ---------------------------------------------------------------------------
module bc_preg_arbiter #(
  parameter int N_REQ         = 4,
  parameter int I_BL_MARC_REG = 6,
  parameter int I_BL_ARC_REG  = 5,
  parameter int D_BL_MARC_REG = 32
) (
  input  logic                             c_clock,
  input  logic                             c_reset,
  input  logic                             c_pause,
  input  logic                             c_flush,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ*I_BL_MARC_REG-1:0]   req_i_preg,
  input  logic [N_REQ*I_BL_ARC_REG-1:0]    req_i_areg,
  input  logic [N_REQ*D_BL_MARC_REG-1:0]   req_d_preg,
  output logic [I_BL_MARC_REG-1:0]         i_preg_rb1,
  output logic [I_BL_ARC_REG-1:0]          i_areg_rb1,
  output logic [D_BL_MARC_REG-1:0]         d_preg_rb1,
  output logic                             s_busy
`ifdef BC_PREG_ARB_STAT_EN
  ,
  output logic [15:0]                      s_cnt_bc,
  output logic [15:0]                      s_cnt_conf
`endif
);

  localparam int IW = I_BL_MARC_REG;
  localparam int AW = I_BL_ARC_REG;
  localparam int DW = D_BL_MARC_REG;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [N_REQ-1:0] hold_v_reg;
  logic [IW-1:0]    hold_preg_reg [N_REQ];
  logic [AW-1:0]    hold_areg_reg [N_REQ];
  logic [DW-1:0]    hold_data_reg [N_REQ];
  logic [PW-1:0]    rr_ptr_reg;

  logic [IW-1:0]    bus_preg_reg;
  logic [AW-1:0]    bus_areg_reg;
  logic [DW-1:0]    bus_data_reg;

  // -------------------------------------------------------------------------
  // Per-pipe unpacking and handshake
  // -------------------------------------------------------------------------
  logic             arb_en;
  logic             gnt_any;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    rr_ptr_next;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] accept;
  logic [N_REQ-1:0] load_live;
  logic [IW-1:0]    in_preg [N_REQ];
  logic [AW-1:0]    in_areg [N_REQ];
  logic [DW-1:0]    in_data [N_REQ];

  // Flush dominates pause; either one blocks both grant and accept.
  assign arb_en = !c_pause && !c_flush;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_pipe
      assign in_preg[gi] = req_i_preg[gi*IW +: IW];
      assign in_areg[gi] = req_i_areg[gi*AW +: AW];
      assign in_data[gi] = req_d_preg[gi*DW +: DW];

      assign gnt[gi] = gnt_any && (gnt_idx == PW'(gi));

      // A slot being granted this cycle can take a new result at the same
      // edge, which lets a single pipe stream one result per cycle.
      assign req_ready[gi] = arb_en && (!hold_v_reg[gi] || gnt[gi]);
      assign accept[gi]    = req_valid[gi] && req_ready[gi];

      // preg index 0 means "no destination": the handshake completes but
      // nothing is kept for broadcast.
      assign load_live[gi] = accept[gi] && (in_preg[gi] != '0);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin grant: first occupied slot starting at rr_ptr, wrapping.
  // The scan runs from the farthest offset down so the nearest one wins.
  // -------------------------------------------------------------------------
  int            scan_pos;
  logic [PW-1:0] scan_idx;

  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_pos = 0;
    scan_idx = '0;
    if (arb_en) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        scan_pos = int'(rr_ptr_reg) + i;
        if (scan_pos >= N_REQ) begin
          scan_pos = scan_pos - N_REQ;
        end
        scan_idx = scan_pos[PW-1:0];
        if (hold_v_reg[scan_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = scan_idx;
        end
      end
    end
  end

  // Explicit wrap keeps the pointer inside 0..N_REQ-1 for any N_REQ.
  assign rr_ptr_next = (gnt_idx == LAST_IDX) ? '0 : (gnt_idx + PW'(1));

  // -------------------------------------------------------------------------
  // Holding slots
  // -------------------------------------------------------------------------
  always_ff @(posedge c_clock or negedge c_reset) begin
    if (!c_reset) begin
      hold_v_reg <= '0;
      for (int k = 0; k < N_REQ; k++) begin
        hold_preg_reg[k] <= '0;
        hold_areg_reg[k] <= '0;
        hold_data_reg[k] <= '0;
      end
    end else if (c_flush) begin
      // Pending results are discarded; payload fields are don't-care.
      hold_v_reg <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (accept[k]) begin
          // Refill on the same edge as a grant keeps the slot occupied with
          // the new entry while the old one goes to the bus.
          hold_v_reg[k]    <= load_live[k];
          hold_preg_reg[k] <= in_preg[k];
          hold_areg_reg[k] <= in_areg[k];
          hold_data_reg[k] <= in_data[k];
        end else if (gnt[k]) begin
          hold_v_reg[k] <= 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Broadcast bus and round-robin pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge c_clock or negedge c_reset) begin
    if (!c_reset) begin
      bus_preg_reg <= '0;
      bus_areg_reg <= '0;
      bus_data_reg <= '0;
      rr_ptr_reg   <= '0;
    end else if (gnt_any) begin
      bus_preg_reg <= hold_preg_reg[gnt_idx];
      bus_areg_reg <= hold_areg_reg[gnt_idx];
      bus_data_reg <= hold_data_reg[gnt_idx];
      rr_ptr_reg   <= rr_ptr_next;
    end else begin
      // Idle, paused or flushed: preg 0 marks the bus empty. areg/data keep
      // their last value to avoid needless toggling.
      bus_preg_reg <= '0;
    end
  end

  assign i_preg_rb1 = bus_preg_reg;
  assign i_areg_rb1 = bus_areg_reg;
  assign d_preg_rb1 = bus_data_reg;
  assign s_busy     = |hold_v_reg;

  // -------------------------------------------------------------------------
  // Optional statistics
  // -------------------------------------------------------------------------
`ifdef BC_PREG_ARB_STAT_EN
  logic [15:0] cnt_bc_reg;
  logic [15:0] cnt_conf_reg;
  logic        contended;

  assign contended = ($countones(hold_v_reg) >= 2);

  always_ff @(posedge c_clock or negedge c_reset) begin
    if (!c_reset) begin
      cnt_bc_reg   <= '0;
      cnt_conf_reg <= '0;
    end else if (gnt_any) begin
      if (cnt_bc_reg != 16'hFFFF) begin
        cnt_bc_reg <= cnt_bc_reg + 16'd1;
      end
      if (contended && (cnt_conf_reg != 16'hFFFF)) begin
        cnt_conf_reg <= cnt_conf_reg + 16'd1;
      end
    end
  end

  assign s_cnt_bc   = cnt_bc_reg;
  assign s_cnt_conf = cnt_conf_reg;
`endif

endmodule
